// File: rtl/gamepad_pmod_tx_pkg.sv
// Shared definitions for the gamepad Pmod transmitter: frame geometry,
// button bit positions, the absent-slot filler word and the FSM state type.
package gamepad_pkg;

  localparam int SLOT_BITS  = 12;
  localparam int FRAME_BITS = 24;

  // Bit positions inside one 12-bit controller word
  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  // An unpopulated slot reads all-ones; the decoder treats that as "no pad"
  localparam logic [SLOT_BITS-1:0] ABSENT_SLOT = 12'hFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } tx_state_e;

  // Controller 2 occupies the upper half so it goes out first (MSB first)
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [SLOT_BITS-1:0] b1,
    input logic [SLOT_BITS-1:0] b2,
    input logic                 p1,
    input logic                 p2
  );
    logic [SLOT_BITS-1:0] hi;
    logic [SLOT_BITS-1:0] lo;
    hi = p2 ? b2 : ABSENT_SLOT;
    lo = p1 ? b1 : ABSENT_SLOT;
    return {hi, lo};
  endfunction

endpackage

// File: rtl/gamepad_tx_phase_timer.sv
// Loadable down-counter shared by the latch, clock-low and clock-high phases.
// Loading N-1 makes tc_o assert in the N-th cycle after the load, so a phase
// that reloads on tc_o lasts exactly N cycles.
module gamepad_tx_phase_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/gamepad_pmod_tx.sv
// Transmit side of the SNES-style gamepad Pmod link (latch / clk / data).
// Snapshots two controller words on a start request and shifts them out as
// one 24-bit frame, MSB first, with the receiver sampling on pmod_clk rise.
//
// Build option: define GAMEPAD_TX_AUTO_EN to add a free-running frame timer
// that raises an internal start every FRAME_PERIOD cycles (start-to-start).
//
// state       | meaning
// ST_IDLE     | waiting for start; all strobes low
// ST_LATCH    | pmod_latch high for LATCH_CYCLES
// ST_SHIFT_LO | pmod_clk low for HALF_PERIOD, current bit on pmod_data
// ST_SHIFT_HI | pmod_clk high for HALF_PERIOD, same bit held
// ST_DONE     | one-cycle done pulse, start ignored
module gamepad_pmod_tx
  import gamepad_pkg::*;
#(
  parameter int unsigned HALF_PERIOD  = 4,
  parameter int unsigned LATCH_CYCLES = 8,
  parameter int unsigned FRAME_PERIOD = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SLOT_BITS-1:0] buttons1,
  input  logic [SLOT_BITS-1:0] buttons2,
  input  logic                 present1,
  input  logic                 present2,
  output logic                 pmod_latch,
  output logic                 pmod_clk,
  output logic                 pmod_data,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PH_MAX = (HALF_PERIOD > LATCH_CYCLES) ? HALF_PERIOD : LATCH_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
  localparam logic [PH_W-1:0] LATCH_LOAD = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0] HALF_LOAD  = PH_W'(HALF_PERIOD - 1);
  localparam logic [4:0]      LAST_BIT   = 5'(FRAME_BITS - 1);

  if (HALF_PERIOD < 1 || LATCH_CYCLES < 1 || FRAME_PERIOD < 1) begin : g_bad_params
    $error("gamepad_pmod_tx: HALF_PERIOD, LATCH_CYCLES and FRAME_PERIOD must be >= 1");
  end

  tx_state_e             state_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [FRAME_BITS-1:0] frame_d;
  logic [4:0]            bit_cnt_q;
  logic                  latch_q;
  logic                  pclk_q;
  logic                  data_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  start_req;
  logic                  ph_load;
  logic [PH_W-1:0]       ph_val;
  logic                  ph_tc;

  assign frame_d = build_frame(buttons1, buttons2, present1, present2);

`ifdef GAMEPAD_TX_AUTO_EN
  localparam int unsigned AUTO_W = (FRAME_PERIOD < 2) ? 1 : $clog2(FRAME_PERIOD);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(FRAME_PERIOD - 1);

  logic [AUTO_W-1:0] auto_cnt_q;
  logic              auto_tick;

  assign auto_tick = (auto_cnt_q == AUTO_LAST);

  // Free-running period counter; a tick that lands while busy is simply lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt_q <= '0;
    end else if (auto_tick) begin
      auto_cnt_q <= '0;
    end else begin
      auto_cnt_q <= auto_cnt_q + 1'b1;
    end
  end

  assign start_req = start | auto_tick;
`else
  assign start_req = start;
`endif

  // Phase timer reload: every phase boundary restarts it with the next length
  always_comb begin
    ph_load = 1'b0;
    ph_val  = HALF_LOAD;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          ph_load = 1'b1;
          ph_val  = LATCH_LOAD;
        end
      end
      ST_LATCH, ST_SHIFT_LO: ph_load = ph_tc;
      ST_SHIFT_HI:           ph_load = ph_tc && (bit_cnt_q != LAST_BIT);
      default:               ph_load = 1'b0;
    endcase
  end

  gamepad_tx_phase_timer #(
    .WIDTH (PH_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .tc_o       (ph_tc)
  );

  // Frame sequencer with registered pin outputs and the shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b0;
      data_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            frame_q   <= frame_d;
            bit_cnt_q <= '0;
            latch_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (ph_tc) begin
            latch_q <= 1'b0;
            data_q  <= frame_q[FRAME_BITS-1];
            frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
            state_q <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (ph_tc) begin
            pclk_q  <= 1'b1;
            state_q <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (ph_tc) begin
            pclk_q <= 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              data_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              data_q    <= frame_q[FRAME_BITS-1];
              frame_q   <= {frame_q[FRAME_BITS-2:0], 1'b0};
              state_q   <= ST_SHIFT_LO;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pmod_latch = latch_q;
  assign pmod_clk   = pclk_q;
  assign pmod_data  = data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Scoreboard bench for gamepad_pmod_tx (default build, no auto timer).
// Stimulus pushes the expected frame word on every accepted start; a monitor
// decodes the pmod wires like a receiver and checks each completed frame.
module tb_gamepad_pmod_tx;

  localparam int HP        = 4;
  localparam int LC        = 8;
  localparam int FRAME_CYC = LC + 48 * HP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] buttons1 = '0;
  logic [11:0] buttons2 = '0;
  logic        present1 = 1'b0;
  logic        present2 = 1'b0;
  logic        pmod_latch;
  logic        pmod_clk;
  logic        pmod_data;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  gamepad_pmod_tx #(
    .HALF_PERIOD  (HP),
    .LATCH_CYCLES (LC),
    .FRAME_PERIOD (1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .buttons1   (buttons1),
    .buttons2   (buttons2),
    .present1   (present1),
    .present2   (present2),
    .pmod_latch (pmod_latch),
    .pmod_clk   (pmod_clk),
    .pmod_data  (pmod_data),
    .busy       (busy),
    .done       (done)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          frames_pushed = 0;
  int          frames_seen = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: an absent slot reads all-ones, controller 2 is the upper half
  function automatic logic [23:0] model_frame(input logic [11:0] b1, input logic [11:0] b2,
                                              input logic p1, input logic p2);
    logic [11:0] hi;
    logic [11:0] lo;
    hi = p2 ? b2 : 12'hFFF;
    lo = p1 ? b1 : 12'hFFF;
    return {hi, lo};
  endfunction

  // Monitor: behaves like a receiver sampling data on each pmod_clk rise
  logic        in_frame = 1'b0;
  int          cyc = 0;
  int          latch_len = 0;
  int          nbits = 0;
  int          clk_in_latch = 0;
  logic [23:0] got = '0;
  logic        held_bit = 1'b0;
  logic        prev_latch = 1'b0;
  logic        prev_clk = 1'b0;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame   = 1'b0;
      prev_latch = 1'b0;
      prev_clk   = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (pmod_latch && !prev_latch) begin
        check("frame_was_requested", 32'(exp_q.size() > 0), 32'd1);
        in_frame     = 1'b1;
        cyc          = 0;
        latch_len    = 1;
        nbits        = 0;
        clk_in_latch = 0;
        got          = '0;
      end else if (in_frame) begin
        cyc++;
        if (pmod_latch) latch_len++;
      end
      if (in_frame) begin
        if (!done) check("busy_during_frame", 32'(busy), 32'd1);
        if (pmod_clk && !prev_clk) begin
          if (pmod_latch) clk_in_latch++;
          got      = {got[22:0], pmod_data};
          nbits++;
          held_bit = pmod_data;
        end else if (pmod_clk && prev_clk) begin
          check("data_stable_clk_high", 32'(pmod_data), 32'(held_bit));
        end
      end
      if (done) begin
        check("done_pulse_width", 32'(prev_done), 32'd0);
        check("done_inside_frame", 32'(in_frame), 32'd1);
        if (in_frame) begin
          if (exp_q.size() > 0) check("frame_word", 32'(got), 32'(exp_q.pop_front()));
          check("rising_edges", 32'(nbits), 32'd24);
          check("latch_length", 32'(latch_len), 32'(LC));
          check("latch_to_done", 32'(cyc), 32'(FRAME_CYC));
          check("clk_edge_in_latch", 32'(clk_in_latch), 32'd0);
          check("done_cycle_pins", {28'd0, busy, pmod_clk, pmod_data, pmod_latch}, 32'd0);
          frames_seen++;
          in_frame = 1'b0;
        end
      end
      prev_latch = pmod_latch;
      prev_clk   = pmod_clk;
      prev_done  = done;
    end
  end

  // Caller sits at a negedge with the DUT idle; returns one negedge after done
  task automatic run_frame(input logic [11:0] b1, input logic [11:0] b2, input logic p1,
                           input logic p2, input bit done_start, input bit fixed_chg);
    bit got_done;
    buttons1 = b1;
    buttons2 = b2;
    present1 = p1;
    present2 = p2;
    start    = 1'b1;
    exp_q.push_back(model_frame(b1, b2, p1, p2));
    frames_pushed++;
    got_done = 1'b0;
    for (int k = 0; k < FRAME_CYC + 20; k++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      start = ($urandom_range(0, 7) == 0);
      if (fixed_chg) begin
        buttons1 = 12'hFFE;
      end else begin
        buttons1 = 12'($urandom);
        buttons2 = 12'($urandom);
        present1 = 1'($urandom);
        present2 = 1'($urandom);
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    start = done_start;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int nr;
    logic pc;
    repeat (3) @(negedge clk);
    check("reset_pins", {27'd0, pmod_latch, pmod_clk, pmod_data, busy, done}, 32'd0);
    rst_n = 1'b1;

    repeat (60) @(negedge clk);
    check("idle_without_start", 32'(busy), 32'd0);

    run_frame(12'h801, 12'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
    run_frame(12'h080, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(12'h000, 12'h5A5, 1'b1, 1'b1, 1'b1, 1'b1);
    run_frame(12'h3C3, 12'h123, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      run_frame(12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    buttons1 = 12'h0F0;
    buttons2 = 12'hABC;
    present1 = 1'b1;
    present2 = 1'b1;
    start    = 1'b1;
    exp_q.push_back(model_frame(buttons1, buttons2, 1'b1, 1'b1));
    @(negedge clk);
    start = 1'b0;
    nr = 0;
    pc = 1'b0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge clk);
      if (pmod_clk && !pc) nr++;
      pc = pmod_clk;
      if (nr == 11) break;
    end
    check("reached_bit_10", 32'(nr), 32'd11);
    #2 rst_n = 1'b0;
    #1 check("async_reset_pins", {27'd0, pmod_latch, pmod_clk, pmod_data, busy, done}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'd0);

    run_frame(12'h7E1, 12'h81F, 1'b1, 1'b1, 1'b0, 1'b0);

    repeat (300) @(negedge clk);
    check("no_spurious_busy", 32'(busy), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("frame_count", 32'(frames_seen), 32'(frames_pushed));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
